credit_pe: RTL

CREDIT_PE -- requirements
Module: credit_pe

---
 rtl/credit_pe.sv | 127 ++++++++++++
 1 files changed

// File: rtl/credit_pe.sv
// credit_pe: credit-based flit injector with round-robin destinations and a receive-side counter path.
// Ports:
//   clk, rst (async, active-low)
//   mode/start/burst_len : TX control (00 idle, 01 continuous, 10 burst, 11 idle)
//   ci                   : one returned credit per high cycle
//   out_data/out_valid   : registered injected flit, valid for one cycle per flit
//   credit_cnt/credit_err: available credits, sticky overflow flag
//   busy/tx_count        : FSM not idle, flits sent
//   in_data/in_valid     : received flit
//   rx_last/rx_count/rx_err_cnt : last flit, flits for this node, misrouted flits (saturating)
module credit_pe #(
  parameter int DATA_W    = 20,
  parameter int ID_W      = 4,
  parameter int NODE_ID   = 4,
  parameter int NUM_NODES = 16,
  parameter int CREDITS   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              start,
  input  logic [7:0]        burst_len,
  input  logic              ci,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [3:0]        credit_cnt,
  output logic              credit_err,
  output logic              busy,
  output logic [15:0]       tx_count,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] rx_last,
  output logic [15:0]       rx_count,
  output logic [7:0]        rx_err_cnt
);
  localparam int SEQ_W = DATA_W - 2 * ID_W;
  localparam logic [ID_W-1:0] MY_ID = ID_W'(NODE_ID);
  localparam logic [ID_W-1:0] DEST0 = ID_W'((NODE_ID + 1) % NUM_NODES);
  localparam logic [3:0] CRED_MAX = 4'(CREDITS);
  typedef enum logic [1:0] {IDLE, CONT, BURST} state_t;
  state_t r_state, w_next;
  logic [ID_W-1:0]   r_dest;
  logic [SEQ_W-1:0]  r_seq;
  logic [7:0]        r_rem;
  logic [3:0]        r_credit;
  logic              r_credit_err;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic [15:0]       r_tx_count;
  logic [DATA_W-1:0] r_rx_last;
  logic [15:0]       r_rx_count;
  logic [7:0]        r_rx_err_cnt;
  logic              w_send;
  logic              w_load;
  logic [DATA_W-1:0] w_flit;
  logic              w_rx_mine;
  // Next destination modulo NUM_NODES, never addressing this node itself.
  function automatic logic [ID_W-1:0] adv(input logic [ID_W-1:0] d);
    logic [ID_W:0] n;
    n = {1'b0, d} + 1'b1;
    if (n >= (ID_W+1)'(NUM_NODES)) n = '0;
    if (n[ID_W-1:0] == MY_ID) n = n + 1'b1;
    if (n >= (ID_W+1)'(NUM_NODES)) n = '0;
    return n[ID_W-1:0];
  endfunction
  assign w_send    = (r_state != IDLE) && (r_credit != 4'd0);
  assign w_load    = (r_state == IDLE) && (mode == 2'b10) && start && (burst_len != 8'd0);
  assign w_flit    = {r_dest, MY_ID, r_seq};
  assign w_rx_mine = in_data[DATA_W-1 -: ID_W] == MY_ID;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (mode == 2'b01) ? CONT : (w_load ? BURST : IDLE);
      CONT:    w_next = (mode != 2'b01) ? IDLE : CONT;
      BURST:   w_next = ((mode != 2'b10) || (w_send && r_rem == 8'd1)) ? IDLE : BURST;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_dest       <= DEST0;
      r_seq        <= '0;
      r_rem        <= '0;
      r_credit     <= CRED_MAX;
      r_credit_err <= 1'b0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_tx_count   <= '0;
    end else begin
      r_state     <= w_next;
      r_out_valid <= w_send;
      if (w_load) r_rem <= burst_len;
      else if (w_send && r_state == BURST) r_rem <= r_rem - 8'd1;
      if (w_send) begin
        r_out_data <= w_flit;
        r_dest     <= adv(r_dest);
        r_seq      <= r_seq + 1'b1;
        r_tx_count <= r_tx_count + 16'd1;
      end
      // A returned credit at full capacity is dropped and flagged.
      if (w_send && !ci) r_credit <= r_credit - 4'd1;
      else if (!w_send && ci && r_credit != CRED_MAX) r_credit <= r_credit + 4'd1;
      else if (!w_send && ci) r_credit_err <= 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_last    <= '0;
      r_rx_count   <= '0;
      r_rx_err_cnt <= '0;
    end else if (in_valid) begin
      r_rx_last <= in_data;
      if (w_rx_mine) r_rx_count <= r_rx_count + 16'd1;
      else if (r_rx_err_cnt != 8'hFF) r_rx_err_cnt <= r_rx_err_cnt + 8'd1;
    end
  end
  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign credit_cnt = r_credit;
  assign credit_err = r_credit_err;
  assign busy       = r_state != IDLE;
  assign tx_count   = r_tx_count;
  assign rx_last    = r_rx_last;
  assign rx_count   = r_rx_count;
  assign rx_err_cnt = r_rx_err_cnt;
endmodule
